axi_mem_responder: RTL and testbench



---
 rtl/axi_mem_responder_if.sv | 48 ++++
 rtl/axi_mem_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_responder_if.sv
// Burst channel bundle between a cache-side master and the memory responder.
// AR/R carry read bursts, AW/W/B carry write bursts.
interface axi_mem_responder_if #(
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned LEN_WIDTH  = 4
);
    logic                  ARVALID;
    logic                  ARREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [LEN_WIDTH-1:0]  ARLEN;
    logic [ID_WIDTH-1:0]   ARID;

    logic                  RVALID;
    logic                  RREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic                  RLAST;
    logic [ID_WIDTH-1:0]   RID;

    logic                  AWVALID;
    logic                  AWREADY;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [LEN_WIDTH-1:0]  AWLEN;
    logic [ID_WIDTH-1:0]   AWID;

    logic                  WVALID;
    logic                  WREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic                  WLAST;
    logic [ID_WIDTH-1:0]   WID;

    logic                  BVALID;
    logic                  BREADY;
    logic [ID_WIDTH-1:0]   BID;

    modport master (
        output ARVALID, ARADDR, ARLEN, ARID, RREADY,
        output AWVALID, AWADDR, AWLEN, AWID, WVALID, WDATA, WLAST, WID, BREADY,
        input  ARREADY, RVALID, RDATA, RLAST, RID, AWREADY, WREADY, BVALID, BID
    );

    modport slave (
        input  ARVALID, ARADDR, ARLEN, ARID, RREADY,
        input  AWVALID, AWADDR, AWLEN, AWID, WVALID, WDATA, WLAST, WID, BREADY,
        output ARREADY, RVALID, RDATA, RLAST, RID, AWREADY, WREADY, BVALID, BID
    );
endinterface

// File: rtl/axi_mem_responder.sv
// Burst memory endpoint: one read and one write burst in flight, independent paths,
// word-addressed array with a fixed programmable read latency.
module axi_mem_responder #(
    parameter int unsigned ADDR_WIDTH     = 26,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned LEN_WIDTH      = 4,
    parameter int unsigned MEM_WORDS_LOG2 = 12,
    parameter int unsigned READ_LATENCY   = 4
) (
    input  logic              clk,
    input  logic              rst,
    axi_mem_responder_if.slave bus,
    output logic              proto_err
);
    localparam int unsigned Words = 1 << MEM_WORDS_LOG2;

    typedef logic [MEM_WORDS_LOG2-1:0] idx_t;
    typedef logic [LEN_WIDTH:0]        cnt_t;
    typedef enum logic [1:0] {RIdle, RWait, RBurst} r_state_e;
    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

    // LEN counts beats directly; zero still means a single beat.
    function automatic cnt_t beats(input logic [LEN_WIDTH-1:0] len);
        return (len == '0) ? cnt_t'(1) : cnt_t'(len);
    endfunction

    logic [DATA_WIDTH-1:0] mem [Words];

    r_state_e              r_state_q, r_state_d;
    idx_t                  r_idx_q, r_idx_d;
    cnt_t                  r_len_q, r_len_d, r_beat_q, r_beat_d;
    logic [3:0]            r_wait_q, r_wait_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;

    w_state_e              w_state_q, w_state_d;
    idx_t                  w_idx_q, w_idx_d;
    cnt_t                  w_len_q, w_len_d, w_beat_q, w_beat_d;
    logic [ID_WIDTH-1:0]   w_id_q, w_id_d, bid_q, bid_d;
    logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic                  proto_err_q, proto_err_d;
    logic                  w_last, wr_en;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.ARADDR[ADDR_WIDTH-1:MEM_WORDS_LOG2+2], bus.ARADDR[1:0],
                                bus.AWADDR[ADDR_WIDTH-1:MEM_WORDS_LOG2+2], bus.AWADDR[1:0]};

    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_beat_d  = r_beat_q;
        r_wait_d  = r_wait_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rid_d     = rid_q;
        unique case (r_state_q)
            RIdle: begin
                if (bus.ARVALID && arready_q) begin
                    r_idx_d   = bus.ARADDR[MEM_WORDS_LOG2+1:2];
                    r_len_d   = beats(bus.ARLEN);
                    r_beat_d  = '0;
                    r_wait_d  = '0;
                    rid_d     = bus.ARID;
                    arready_d = 1'b0;
                    if (READ_LATENCY == 0) begin
                        r_state_d = RBurst;
                        rvalid_d  = 1'b1;
                        rdata_d   = mem[r_idx_d];
                        rlast_d   = (r_len_d == cnt_t'(1));
                    end else begin
                        r_state_d = RWait;
                    end
                end
            end
            RWait: begin
                r_wait_d = r_wait_q + 4'd1;
                if (32'(r_wait_q) + 32'd1 == READ_LATENCY) begin
                    r_state_d = RBurst;
                    rvalid_d  = 1'b1;
                    rdata_d   = mem[r_idx_q];
                    rlast_d   = (r_len_q == cnt_t'(1));
                end
            end
            RBurst: begin
                if (bus.RREADY) begin
                    if (rlast_q) begin
                        r_state_d = RIdle;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                    end else begin
                        // Array is sampled at the edge, so a same-edge write yields old data.
                        r_idx_d  = r_idx_q + idx_t'(1);
                        r_beat_d = r_beat_q + cnt_t'(1);
                        rdata_d  = mem[r_idx_d];
                        rlast_d  = (r_beat_q + cnt_t'(2) == r_len_q);
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    always_comb begin
        w_state_d   = w_state_q;
        w_idx_d     = w_idx_q;
        w_len_d     = w_len_q;
        w_beat_d    = w_beat_q;
        w_id_d      = w_id_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bid_d       = bid_q;
        proto_err_d = proto_err_q;
        w_last      = (w_beat_q + cnt_t'(1) == w_len_q);
        unique case (w_state_q)
            WIdle: begin
                if (bus.AWVALID && awready_q) begin
                    w_idx_d   = bus.AWADDR[MEM_WORDS_LOG2+1:2];
                    w_len_d   = beats(bus.AWLEN);
                    w_beat_d  = '0;
                    w_id_d    = bus.AWID;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = WData;
                end
            end
            WData: begin
                if (bus.WVALID) begin
                    // Burst length comes from AWLEN; WLAST/WID are only checked.
                    if ((bus.WLAST != w_last) || (bus.WID != w_id_q)) proto_err_d = 1'b1;
                    if (w_last) begin
                        w_state_d = WResp;
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bid_d     = w_id_q;
                    end else begin
                        w_idx_d  = w_idx_q + idx_t'(1);
                        w_beat_d = w_beat_q + cnt_t'(1);
                    end
                end
            end
            WResp: begin
                if (bus.BREADY) begin
                    w_state_d = WIdle;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    assign wr_en = (w_state_q == WData) && bus.WVALID;

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[w_idx_q] <= bus.WDATA;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q   <= RIdle;
            r_idx_q     <= '0;
            r_len_q     <= '0;
            r_beat_q    <= '0;
            r_wait_q    <= '0;
            arready_q   <= 1'b1;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rdata_q     <= '0;
            rid_q       <= '0;
            w_state_q   <= WIdle;
            w_idx_q     <= '0;
            w_len_q     <= '0;
            w_beat_q    <= '0;
            w_id_q      <= '0;
            awready_q   <= 1'b1;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bid_q       <= '0;
            proto_err_q <= 1'b0;
        end else begin
            r_state_q   <= r_state_d;
            r_idx_q     <= r_idx_d;
            r_len_q     <= r_len_d;
            r_beat_q    <= r_beat_d;
            r_wait_q    <= r_wait_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
            rdata_q     <= rdata_d;
            rid_q       <= rid_d;
            w_state_q   <= w_state_d;
            w_idx_q     <= w_idx_d;
            w_len_q     <= w_len_d;
            w_beat_q    <= w_beat_d;
            w_id_q      <= w_id_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bid_q       <= bid_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign bus.ARREADY = arready_q;
    assign bus.RVALID  = rvalid_q;
    assign bus.RDATA   = rdata_q;
    assign bus.RLAST   = rlast_q;
    assign bus.RID     = rid_q;
    assign bus.AWREADY = awready_q;
    assign bus.WREADY  = wready_q;
    assign bus.BVALID  = bvalid_q;
    assign bus.BID     = bid_q;
    assign proto_err   = proto_err_q;
endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: directed scenarios plus random bursts, scored against
// a flat reference memory through expected-response queues.
module tb_axi_mem_responder;
    localparam int AW  = 26;
    localparam int DW  = 32;
    localparam int IW  = 4;
    localparam int LW  = 4;
    localparam int ML  = 12;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic proto_err;

    always #5 clk = ~clk;

    axi_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW)) bus ();

    axi_mem_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW),
        .MEM_WORDS_LOG2(ML), .READ_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .proto_err(proto_err)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  tid;
        logic        last;
    } rbeat_t;

    rbeat_t      r_exp[$];
    logic [3:0]  b_exp[$];
    logic [31:0] ref_mem [4096];
    logic [31:0] wbuf [16];
    logic        exp_perr = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle a response is presented it must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.RVALID) begin
                if (r_exp.size() == 0) check("r_spurious", 32'(bus.RVALID), 0);
                else begin
                    check("rdata", bus.RDATA, r_exp[0].data);
                    check("rid", 32'(bus.RID), 32'(r_exp[0].tid));
                    check("rlast", 32'(bus.RLAST), 32'(r_exp[0].last));
                    if (bus.RREADY) void'(r_exp.pop_front());
                end
            end
            if (bus.BVALID) begin
                if (b_exp.size() == 0) check("b_spurious", 32'(bus.BVALID), 0);
                else begin
                    check("bid", 32'(bus.BID), 32'(b_exp[0]));
                    if (bus.BREADY) void'(b_exp.pop_front());
                end
            end
        end
    end

    task automatic axi_write(input logic [25:0] addr, input logic [3:0] len,
                             input logic [3:0] tid, input int bad_beat);
        int nb;
        int n;
        logic [11:0] idx;
        nb  = (len == 4'd0) ? 1 : int'(len);
        idx = addr[13:2];
        for (int i = 0; i < nb; i++) ref_mem[idx + 12'(i)] = wbuf[i];
        b_exp.push_back(tid);
        bus.AWVALID = 1'b1;
        bus.AWADDR  = addr;
        bus.AWLEN   = len;
        bus.AWID    = tid;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.AWREADY && n < 200);
        check("awready", 32'(bus.AWREADY), 1);
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;
        for (int i = 0; i < nb; i++) begin
            bus.WVALID = 1'b1;
            bus.WDATA  = wbuf[i];
            bus.WID    = tid;
            bus.WLAST  = (i == nb - 1) ^ (i == bad_beat);
            n = 0;
            do begin @(negedge clk); n++; end while (!bus.WREADY && n < 200);
            check("wready", 32'(bus.WREADY), 1);
            check("proto_err", 32'(proto_err), 32'(exp_perr));
            @(posedge clk); #1;
            if (i == bad_beat) exp_perr = 1'b1;
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        @(negedge clk);
        check("proto_err_end", 32'(proto_err), 32'(exp_perr));
        check("bvalid_after_last_w", 32'(bus.BVALID), 1);
        check("bid_after_last_w", 32'(bus.BID), 32'(tid));
        n = 0;
        while (b_exp.size() != 0 && n < 200) begin @(posedge clk); n++; end
        check("b_drained", 32'(b_exp.size()), 0);
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [25:0] addr, input logic [3:0] len, input logic [3:0] tid,
                            input int stall_beat, input int stall_cyc);
        int nb;
        int n;
        logic [11:0] idx;
        nb  = (len == 4'd0) ? 1 : int'(len);
        idx = addr[13:2];
        for (int i = 0; i < nb; i++)
            r_exp.push_back('{data: ref_mem[idx + 12'(i)], tid: tid, last: (i == nb - 1)});
        bus.ARVALID = 1'b1;
        bus.ARADDR  = addr;
        bus.ARLEN   = len;
        bus.ARID    = tid;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.ARREADY && n < 200);
        check("arready", 32'(bus.ARREADY), 1);
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.RVALID && n < 100);
        check("r_first_latency", 32'(n), 32'(1 + LAT));
        if (stall_cyc > 0 && stall_beat > 0 && stall_beat < nb) begin
            repeat (stall_beat) @(posedge clk);
            #1 bus.RREADY = 1'b0;
            repeat (stall_cyc) @(posedge clk);
            #1 bus.RREADY = 1'b1;
        end
        n = 0;
        while (r_exp.size() != 0 && n < 300) begin @(posedge clk); n++; end
        check("r_drained", 32'(r_exp.size()), 0);
        @(negedge clk);
        check("rvalid_after_last", 32'(bus.RVALID), 0);
        check("arready_after_last", 32'(bus.ARREADY), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [25:0] a;
        logic [3:0]  l;
        logic [3:0]  t;
        int n;
        bus.ARVALID = 0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARID = '0; bus.RREADY = 1;
        bus.AWVALID = 0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWID = '0;
        bus.WVALID = 0; bus.WDATA = '0; bus.WLAST = 0; bus.WID = '0; bus.BREADY = 1;

        #12;
        check("rst_arready", 32'(bus.ARREADY), 1);
        check("rst_awready", 32'(bus.AWREADY), 1);
        check("rst_rvalid", 32'(bus.RVALID), 0);
        check("rst_rlast", 32'(bus.RLAST), 0);
        check("rst_wready", 32'(bus.WREADY), 0);
        check("rst_bvalid", 32'(bus.BVALID), 0);
        check("rst_proto_err", 32'(proto_err), 0);
        check("rst_rdata", bus.RDATA, 0);
        check("rst_rid", 32'(bus.RID), 0);
        check("rst_bid", 32'(bus.BID), 0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // Prefill words 0..255 so every later read hits known data.
        for (int k = 0; k < 32; k++) begin
            for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
            axi_write(26'(k * 32), 4'd8, 4'(k), -1);
        end

        // Write then read with a 3-cycle stall on the second beat.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
        axi_write(26'h40, 4'd4, 4'd0, -1);
        axi_read(26'h40, 4'd4, 4'd8, 1, 3);

        // Index wrap from the top word to word 0.
        wbuf[0] = 32'h11;
        wbuf[1] = 32'h22;
        axi_write(26'h3FFC, 4'd2, 4'd1, -1);
        axi_read(26'h3FFC, 4'd1, 4'd2, 0, 0);
        axi_read(26'h0, 4'd1, 4'd3, 0, 0);
        axi_read(26'h3FFD, 4'd2, 4'd4, 1, 2);

        // WLAST on beat 2 of 4, then a clean burst with the flag still set.
        for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
        axi_write(26'h100, 4'd4, 4'd5, 1);
        axi_write(26'h120, 4'd2, 4'd6, -1);
        axi_read(26'h100, 4'd4, 4'd7, 0, 0);

        // Concurrent write and read with BREADY held off.
        for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
        bus.BREADY = 1'b0;
        fork
            axi_write(26'h2000, 4'd6, 4'd9, -1);
            axi_read(26'h200, 4'd10, 4'd2, 0, 0);
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (!bus.BVALID && n < 300);
                repeat (5) @(posedge clk);
                #1 bus.BREADY = 1'b1;
            end
        join
        axi_read(26'h2000, 4'd6, 4'd10, 2, 1);

        // Asynchronous reset in the middle of the second read beat.
        r_exp.push_back('{data: 32'hA0, tid: 4'd3, last: 1'b0});
        r_exp.push_back('{data: 32'hA1, tid: 4'd3, last: 1'b0});
        bus.ARVALID = 1'b1; bus.ARADDR = 26'h40; bus.ARLEN = 4'd4; bus.ARID = 4'd3;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.ARREADY && n < 200);
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.RVALID && n < 100);
        check("rst_test_rvalid_seen", 32'(bus.RVALID), 1);
        @(posedge clk); #2;
        rst = 1'b1;
        r_exp.delete();
        exp_perr = 1'b0;
        #1;
        check("async_rst_rvalid", 32'(bus.RVALID), 0);
        check("async_rst_arready", 32'(bus.ARREADY), 1);
        check("async_rst_awready", 32'(bus.AWREADY), 1);
        check("async_rst_proto_err", 32'(proto_err), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        axi_read(26'h40, 4'd4, 4'd8, 0, 0);

        // Random traffic in the prefilled region, with stray address bits set.
        for (int k = 0; k < 40; k++) begin
            a = {12'($urandom), 2'b00, 10'($urandom_range(0, 239)), 2'($urandom)};
            l = 4'($urandom_range(0, 15));
            t = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
                axi_write(a, l, t, -1);
            end else begin
                axi_read(a, l, t, int'($urandom_range(1, 3)), int'($urandom_range(0, 4)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
